// File: rtl/compressor_pkg.sv
// Shared types and helpers for the compressor gain-envelope controller.
package compressor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } comp_state_t;

  // Q1.15 unity gain
  localparam logic [15:0] GAIN_UNITY = 16'h8000;

  // Magnitude of a signed 16-bit sample. -32768 has no positive
  // counterpart, so it saturates to 16'h7FFF.
  function automatic logic [15:0] sat_abs16(input logic [15:0] x);
    logic [15:0] r;
    if (x == 16'h8000) begin
      r = 16'h7FFF;
    end else if (x[15]) begin
      r = ~x + 16'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/compressor_level_detect.sv
// Combinational level detector: saturating magnitude and threshold compare.
module compressor_level_detect
  import compressor_pkg::*;
#(
  parameter logic [15:0] THRESHOLD = 16'd8192
) (
  input  logic [15:0] sample_in,
  output logic        over
);

  logic [15:0] level;

  // Compression engages only when the magnitude is strictly above threshold.
  always_comb begin
    level = sat_abs16(sample_in);
    over  = (level > THRESHOLD);
  end

endmodule

// File: rtl/compressor_gain_ctrl.sv
// Gain-envelope controller: steps the Q1.15 gain down while the input is
// over threshold, holds, then steps it back up to unity.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | unity gain, waiting for a sample over threshold
// ATTACK  | over threshold; gain drops one step every ATTACK_DIV samples
// HOLD    | under threshold; waiting HOLD_SAMPLES before releasing
// RELEASE | gain rises one step every RELEASE_DIV samples until unity
module compressor_gain_ctrl
  import compressor_pkg::*;
#(
  parameter logic [15:0] THRESHOLD    = 16'd8192,
  parameter logic [15:0] ATTACK_DIV   = 16'd48,
  parameter logic [15:0] RELEASE_DIV  = 16'd4800,
  parameter logic [15:0] HOLD_SAMPLES = 16'd480,
  parameter logic [15:0] ATTACK_STEP  = 16'h0200,
  parameter logic [15:0] RELEASE_STEP = 16'h0040,
  parameter logic [15:0] GAIN_MIN     = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  input  logic        bypass,
  output logic [15:0] gain,
  output logic        gain_valid,
  output logic        compression_active,
  output logic [1:0]  state,
  output logic [15:0] attack_counter,
  output logic [15:0] release_counter
);

  comp_state_t state_q, state_n;
  logic [15:0] gain_q, gain_n;
  logic [15:0] ac_q, ac_n;
  logic [15:0] rc_q, rc_n;
  logic        over;

  logic [16:0] gain_sub;
  logic [16:0] gain_add;
  logic [15:0] gain_dec;
  logic [15:0] gain_inc;

  compressor_level_detect #(
    .THRESHOLD (THRESHOLD)
  ) u_level (
    .sample_in (sample_in),
    .over      (over)
  );

  // Clamped gain step candidates; the 17th bit catches borrow and carry.
  always_comb begin
    gain_sub = {1'b0, gain_q} - {1'b0, ATTACK_STEP};
    gain_add = {1'b0, gain_q} + {1'b0, RELEASE_STEP};
    if (gain_sub[16] || (gain_sub[15:0] < GAIN_MIN)) begin
      gain_dec = GAIN_MIN;
    end else begin
      gain_dec = gain_sub[15:0];
    end
    if (gain_add >= {1'b0, GAIN_UNITY}) begin
      gain_inc = GAIN_UNITY;
    end else begin
      gain_inc = gain_add[15:0];
    end
  end

  // Next-state, counter and gain decode; everything holds between strobes.
  always_comb begin
    state_n = state_q;
    gain_n  = gain_q;
    ac_n    = ac_q;
    rc_n    = rc_q;
    if (bypass) begin
      state_n = IDLE;
      gain_n  = GAIN_UNITY;
      ac_n    = 16'd0;
      rc_n    = 16'd0;
    end else if (sample_valid) begin
      case (state_q)
        IDLE: begin
          gain_n = GAIN_UNITY;
          if (over) begin
            state_n = ATTACK;
            ac_n    = 16'd0;
          end
        end
        ATTACK: begin
          if (!over) begin
            state_n = HOLD;
            rc_n    = 16'd0;
          end else if (ac_q == ATTACK_DIV - 16'd1) begin
            ac_n   = 16'd0;
            gain_n = gain_dec;
          end else begin
            ac_n = ac_q + 16'd1;
          end
        end
        HOLD: begin
          if (over) begin
            state_n = ATTACK;
            ac_n    = 16'd0;
          end else if (rc_q == HOLD_SAMPLES - 16'd1) begin
            state_n = RELEASE;
            rc_n    = 16'd0;
          end else begin
            rc_n = rc_q + 16'd1;
          end
        end
        RELEASE: begin
          if (over) begin
            state_n = ATTACK;
            ac_n    = 16'd0;
          end else if (rc_q == RELEASE_DIV - 16'd1) begin
            rc_n   = 16'd0;
            gain_n = gain_inc;
            if (gain_inc == GAIN_UNITY) begin
              state_n = IDLE;
            end
          end else begin
            rc_n = rc_q + 16'd1;
          end
        end
        default: begin
          state_n = IDLE;
          gain_n  = GAIN_UNITY;
          ac_n    = 16'd0;
          rc_n    = 16'd0;
        end
      endcase
    end
  end

  // Register state, gain and counters; active flag decodes the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      gain_q             <= GAIN_UNITY;
      ac_q               <= 16'd0;
      rc_q               <= 16'd0;
      gain_valid         <= 1'b0;
      compression_active <= 1'b0;
    end else begin
      state_q            <= state_n;
      gain_q             <= gain_n;
      ac_q               <= ac_n;
      rc_q               <= rc_n;
      gain_valid         <= sample_valid;
      compression_active <= (state_n != IDLE);
    end
  end

  assign gain            = gain_q;
  assign state           = state_q;
  assign attack_counter  = ac_q;
  assign release_counter = rc_q;

endmodule

// File: tb/tb_compressor_gain_ctrl.sv
// Directed bench for compressor_gain_ctrl with a short-time-constant
// parameter set so every phase of the envelope is reachable quickly.
module tb_compressor_gain_ctrl;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic        bypass;
  logic [15:0] gain;
  logic        gain_valid;
  logic        compression_active;
  logic [1:0]  state;
  logic [15:0] attack_counter;
  logic [15:0] release_counter;

  int checks = 0;
  int errors = 0;
  int gv_pulses = 0;
  int strobes = 0;
  logic [15:0] g_exp;
  logic [15:0] atk_gain [12];

  compressor_gain_ctrl #(
    .THRESHOLD    (16'h2000),
    .ATTACK_DIV   (16'd2),
    .RELEASE_DIV  (16'd4),
    .HOLD_SAMPLES (16'd3),
    .ATTACK_STEP  (16'h1000),
    .RELEASE_STEP (16'h0800),
    .GAIN_MIN     (16'h4000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .sample_valid       (sample_valid),
    .sample_in          (sample_in),
    .bypass             (bypass),
    .gain               (gain),
    .gain_valid         (gain_valid),
    .compression_active (compression_active),
    .state              (state),
    .attack_counter     (attack_counter),
    .release_counter    (release_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (gain_valid) gv_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] s);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    if (v) strobes++;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  initial begin
    atk_gain = '{16'h8000, 16'h8000, 16'h7000, 16'h7000, 16'h6000, 16'h6000,
                 16'h5000, 16'h5000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    rst = 1'b1; bypass = 1'b0; sample_valid = 1'b0; sample_in = 16'h0000;

    // 1. reset with strobes present
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'h3000);
      chk("rst_gain", gain, 16'h8000);
      chk("rst_state", state, 2'd0);
      chk("rst_gv", gain_valid, 1'b0);
      chk("rst_ac", attack_counter, 16'd0);
      chk("rst_rc", release_counter, 16'd0);
      chk("rst_ca", compression_active, 1'b0);
    end
    @(negedge clk); rst = 1'b0;

    // 2. attack down to the floor
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 16'h3000);
      chk("atk_state", state, 2'd1);
      chk("atk_gain", gain, atk_gain[i]);
      chk("atk_ac", attack_counter, (i % 2 == 0) ? 16'd0 : 16'd1);
      chk("atk_gv", gain_valid, 1'b1);
    end
    chk("atk_ca", compression_active, 1'b1);

    // 3. hold then release back to unity
    step(1'b1, 16'h0100);
    chk("hold_state", state, 2'd2);
    chk("hold_rc0", release_counter, 16'd0);
    step(1'b1, 16'h0100);
    chk("hold_rc1", release_counter, 16'd1);
    step(1'b1, 16'h0100);
    chk("hold_rc2", release_counter, 16'd2);
    step(1'b1, 16'h0100);
    chk("rel_state", state, 2'd3);
    chk("rel_rc0", release_counter, 16'd0);
    g_exp = 16'h4000;
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        step(1'b1, 16'h0100);
        chk("rel_gain_hold", gain, g_exp);
      end
      step(1'b1, 16'h0100);
      g_exp = g_exp + 16'h0800;
      chk("rel_gain_step", gain, g_exp);
      if (k < 8) chk("rel_state_mid", state, 2'd3);
    end
    chk("rel_end_gain", gain, 16'h8000);
    chk("rel_end_state", state, 2'd0);
    chk("rel_end_ca", compression_active, 1'b0);

    // 4. negative full scale from IDLE
    step(1'b1, 16'h8000);
    chk("nfs_state", state, 2'd1);
    chk("nfs_ca", compression_active, 1'b1);
    chk("nfs_gain", gain, 16'h8000);
    chk("nfs_ac", attack_counter, 16'd0);
    step(1'b1, 16'h3000);
    chk("nfs_ac1", attack_counter, 16'd1);
    step(1'b1, 16'h3000);
    chk("nfs_gain2", gain, 16'h7000);

    // 5. retrigger from HOLD with release_counter=1
    step(1'b1, 16'h0100);
    chk("rt_hold", state, 2'd2);
    step(1'b1, 16'h0100);
    chk("rt_rc1", release_counter, 16'd1);
    step(1'b1, 16'h3000);
    chk("rt_state", state, 2'd1);
    chk("rt_ac", attack_counter, 16'd0);
    chk("rt_gain", gain, 16'h7000);

    // 6a. bypass mid-attack without a strobe
    step(1'b1, 16'h3000);
    step(1'b1, 16'h3000);
    chk("byp_pre_gain", gain, 16'h6000);
    @(negedge clk); bypass = 1'b1; sample_valid = 1'b0;
    @(posedge clk); #1;
    chk("byp_gain", gain, 16'h8000);
    chk("byp_state", state, 2'd0);
    chk("byp_ac", attack_counter, 16'd0);
    chk("byp_rc", release_counter, 16'd0);
    chk("byp_gv", gain_valid, 1'b0);
    chk("byp_ca", compression_active, 1'b0);
    @(negedge clk); bypass = 1'b0;

    // 6b. gaps between strobes freeze everything
    @(posedge clk); #1;
    gv_pulses = 0; strobes = 0;
    step(1'b1, 16'h3000);
    chk("gap_state", state, 2'd1);
    chk("gap_gv", gain_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h3000);
      chk("gap_gv0", gain_valid, 1'b0);
      chk("gap_ac_frz", attack_counter, 16'd0);
      chk("gap_st_frz", state, 2'd1);
    end
    step(1'b1, 16'h3000);
    chk("gap_ac1", attack_counter, 16'd1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'h3000);
      chk("gap_ac1_frz", attack_counter, 16'd1);
      chk("gap_gain_frz", gain, 16'h8000);
    end
    step(1'b1, 16'h3000);
    chk("gap_gain", gain, 16'h7000);
    step(1'b0, 16'h0000);
    chk("gap_pulses", gv_pulses, strobes);

    // rst and bypass together mid-operation
    @(negedge clk); rst = 1'b1; bypass = 1'b1; sample_valid = 1'b1; sample_in = 16'h3000;
    @(posedge clk); #1;
    chk("rst2_gain", gain, 16'h8000);
    chk("rst2_state", state, 2'd0);
    chk("rst2_gv", gain_valid, 1'b0);
    chk("rst2_ac", attack_counter, 16'd0);
    @(negedge clk); rst = 1'b0; bypass = 1'b0; sample_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/compressor_gain_ctrl.md
Name: compressor_gain_ctrl

Overview:
Gain-envelope controller for the compressor datapath. Runs once per audio sample: takes the signed 16-bit sample, compares its magnitude to a threshold and steps a Q1.15 gain down (attack) or back up (release), with a hold period between the two. The registered `gain` feeds the compressor multiplier. `attack_counter`, `release_counter` and `compression_active` are exported for GAO debug capture.

Parameters:
- THRESHOLD, 16'd8192: magnitude above which compression engages (strictly greater).
- ATTACK_DIV, 16'd48: samples per attack gain step; must be >= 1.
- RELEASE_DIV, 16'd4800: samples per release gain step; must be >= 1.
- HOLD_SAMPLES, 16'd480: samples below threshold before release starts; must be >= 1.
- ATTACK_STEP, 16'h0200: gain decrement per attack step.
- RELEASE_STEP, 16'h0040: gain increment per release step.
- GAIN_MIN, 16'h2000: gain floor, Q1.15; must be <= 16'h8000.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_valid  in  1  one-cycle strobe per sample; back-to-back strobes are legal.
- sample_in  in  16  signed sample; valid only with sample_valid.
- bypass  in  1  level input; forces unity gain.
- gain  out  16  unsigned Q1.15; 16'h8000 = 1.0.
- gain_valid  out  1  pulses one cycle after each sample_valid.
- compression_active  out  1  high when state != IDLE.
- state  out  2  IDLE=0, ATTACK=1, HOLD=2, RELEASE=3.
- attack_counter  out  16  attack step timer.
- release_counter  out  16  hold/release timer.

Behaviour:
- Clock and reset: one clock domain (`clk`). Reset is synchronous and active-high (`rst`).
- Reset values: gain=16'h8000, state=IDLE, both counters=0, gain_valid=0, compression_active=0.
- Update timing:
  - State, counters and gain update only on an edge where sample_valid=1; otherwise all hold.
  - gain_valid <= sample_valid, so latency is 1 cycle and gain_valid aligns with the updated gain.
- Level detection:
  - level = |sample_in|; 16'h8000 saturates to 16'h7FFF.
  - over = (level > THRESHOLD).
- IDLE:
  - gain=16'h8000.
  - If over: go to ATTACK, attack_counter=0.
- ATTACK:
  - If !over: go to HOLD, release_counter=0; gain unchanged.
  - Else if attack_counter==ATTACK_DIV-1: attack_counter=0; gain = max(gain-ATTACK_STEP, GAIN_MIN).
  - Else: attack_counter++.
- HOLD:
  - If over: go to ATTACK, attack_counter=0.
  - Else if release_counter==HOLD_SAMPLES-1: go to RELEASE, release_counter=0.
  - Else: release_counter++.
- RELEASE:
  - If over: go to ATTACK, attack_counter=0; gain unchanged.
  - Else if release_counter==RELEASE_DIV-1: release_counter=0; gain = min(gain+RELEASE_STEP, 16'h8000). If the new gain equals 16'h8000, go to IDLE.
  - Else: release_counter++.
- Arithmetic: 17-bit intermediates for add and subtract; no wrap under any parameter set.
- compression_active is a registered decode of the next state.
- bypass=1:
  - On the next edge, regardless of sample_valid: state=IDLE, counters=0, gain=16'h8000.
  - gain_valid still follows sample_valid.
  - Deasserting bypass resumes from IDLE.
- rst mid-operation: every output returns to its reset value on that edge; no partial step is applied.
- Simultaneous rst and bypass: rst wins; the outcome is identical either way.

Decomposition:
- compressor_pkg holds:
  - comp_state_t enum (IDLE/ATTACK/HOLD/RELEASE, 2 bits).
  - GAIN_UNITY=16'h8000.
  - The sat_abs16 function.
- One natural sub-module, compressor_level_detect: sat-abs plus threshold compare. It is combinational; `over` is sampled by the FSM.
- FSM, counters and gain register stay in compressor_gain_ctrl.

Test Plan:
Tests 2-5 use THRESHOLD=16'h2000, ATTACK_DIV=2, RELEASE_DIV=4, HOLD_SAMPLES=3, ATTACK_STEP=16'h1000, RELEASE_STEP=16'h0800, GAIN_MIN=16'h4000.
1. Reset: hold rst high for 2 cycles while strobing sample_valid -> gain=16'h8000, state=0, gain_valid=0, counters=0.
2. Attack to floor: drive 12 strobes of 16'h3000.
   - Strobe 1 -> state=ATTACK.
   - Strobes 3/5/7/9 -> gain 7000/6000/5000/4000.
   - Strobes 10-12 -> gain holds 16'h4000; compression_active=1.
3. Hold and release: then drive 16'h0100.
   - Strobe 1 -> HOLD; strobe 4 -> RELEASE.
   - Gain rises 16'h0800 every 4th strobe thereafter.
   - After 8 steps gain=16'h8000, state=IDLE, compression_active=0.
4. Negative full scale: drive sample_in=16'h8000 from IDLE -> level 16'h7FFF, state=ATTACK on the next cycle; no overflow.
5. Retrigger in HOLD: drive 16'h3000 while in HOLD with release_counter=1 -> state=ATTACK, attack_counter=0, gain unchanged.
6. Bypass and idle cycles:
   - Assert bypass mid-ATTACK with gain=16'h6000 and no sample_valid -> next cycle gain=16'h8000, state=IDLE, counters=0.
   - Separately, gaps between strobes -> all state frozen; gain_valid pulses exactly once per strobe.
